// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time and
// holds the returned word for the control unit until the core retires it.

package instr_fetch_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        PC_4 = 2'd0,
        PC_B = 2'd1,
        PC_J = 2'd2
    } pc_src_t;

    localparam word_t NOP_INSTR = 32'h0000_0013;
endpackage

module instr_fetch_unit
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  pc_src_t     pc_src,
    input  logic        alu_zero,
    input  logic [31:0] imm_b,
    input  logic [31:0] imm_j,
    input  logic        retire,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  word_t       imem_rdata,
    output word_t       instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic        fetch_fault
);

    localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    word_t            instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             req_q, req_d;
    logic             fault_q, fault_d;

    logic [31:0]      pc_plus4;
    logic [31:0]      next_pc;
    logic [CNT_W-1:0] cnt_inc;

    // Target selection; all adds are modular so the PC wraps past the top of memory.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        next_pc  = pc_plus4;
        case (pc_src)
            PC_4:    next_pc = pc_plus4;
            PC_B:    next_pc = alu_zero ? (pc_q + imm_b) : pc_plus4;
            PC_J:    next_pc = pc_q + imm_j;
            default: next_pc = pc_plus4;
        endcase
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        valid_d = valid_q;
        req_d   = 1'b0;
        fault_d = fault_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                req_d   = 1'b1;
            end

            S_REQ: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end

            // A response landing on the final allowed cycle still counts as on time.
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end else if (cnt_inc == CNT_MAX) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end
            end

            S_HOLD: begin
                if (retire) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    if (next_pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end

            S_FAULT: begin
                fault_d = 1'b1;
                valid_d = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            fault_q <= fault_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign fetch_fault = fault_q;

endmodule
